// File: rtl/dwrr_fifo_mux.sv
// dwrr_fifo_mux: per-channel FIFOs drained by a deficit weighted round robin.
// Define DWRR_DROP_CNT_EN to add per-channel saturating drop counters.
module dwrr_fifo_mux #(
   parameter int NUM_REQS = 4,
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int QWID     = 4,
   localparam int CW      = (NUM_REQS > 2) ? $clog2(NUM_REQS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQS-1:0]        push,
   input  logic [NUM_REQS*WIDTH-1:0]  flat_data_in,
   input  logic [NUM_REQS*QWID-1:0]   quantums,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           data_out,
   output logic [NUM_REQS-1:0]        gnt,
   output logic [CW-1:0]              out_chan,
   output logic [NUM_REQS-1:0]        full,
   output logic [NUM_REQS-1:0]        empty
`ifdef DWRR_DROP_CNT_EN
   ,
   output logic [NUM_REQS*8-1:0]      drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULLV = (AW+1)'(DEPTH);
   localparam logic [QWID:0] DMAX = '1;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     ptr_q, ptr_d;
   logic [QWID:0]     def_q [NUM_REQS];
   logic [QWID:0]     def_d [NUM_REQS];

   logic [WIDTH-1:0]  mem_q [NUM_REQS][DEPTH];
   logic [AW-1:0]     wp_q  [NUM_REQS];
   logic [AW-1:0]     rp_q  [NUM_REQS];
   logic [AW:0]       cnt_q [NUM_REQS];
   logic [AW:0]       cnt_d [NUM_REQS];

   logic [WIDTH-1:0]  din   [NUM_REQS];
   logic [WIDTH-1:0]  head  [NUM_REQS];
   logic [QWID-1:0]   qarr  [NUM_REQS];
   logic [NUM_REQS-1:0] elig;
   logic [NUM_REQS-1:0] wr_en;
   logic [NUM_REQS-1:0] pop;
   logic              xfer;
   logic              found;
   logic [CW-1:0]     sel;
   logic [QWID+1:0]   sum;
   int                idx;

   // Unpack the flat buses and derive per-channel FIFO status
   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         din[i]   = flat_data_in[i*WIDTH +: WIDTH];
         qarr[i]  = quantums[i*QWID +: QWID];
         head[i]  = mem_q[i][rp_q[i]];
         full[i]  = (cnt_q[i] == FULLV);
         empty[i] = (cnt_q[i] == '0);
         elig[i]  = !empty[i] && (qarr[i] != '0);
         wr_en[i] = push[i] && (!full[i] || pop[i]);
         cnt_d[i] = cnt_q[i] + {{AW{1'b0}}, wr_en[i]}
                             - {{AW{1'b0}}, pop[i]};
      end
   end

   // Output side of the served channel; nothing shows unless it can move
   always_comb begin
      out_valid = (state_q == SERVE) && !empty[ptr_q]
                  && (def_q[ptr_q] != '0);
      xfer      = out_valid && out_ready;
      data_out  = out_valid ? head[ptr_q] : '0;
      gnt       = xfer ? (NUM_REQS'(1) << ptr_q) : '0;
      pop       = gnt;
      out_chan  = ptr_q;
   end

   // Round-robin search starting just after the last served channel
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQS; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQS;
         if (!found && elig[idx]) begin
            found = 1'b1;
            sel   = CW'(idx);
         end
      end
   end

   // Arbiter next state: credit on selection, spend one per word
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      def_d   = def_q;
      sum     = {1'b0, def_q[sel]} + {2'b00, qarr[sel]};
      unique case (state_q)
         IDLE: begin
            if (found) begin
               ptr_d      = sel;
               def_d[sel] = sum[QWID+1] ? DMAX : sum[QWID:0];
               state_d    = SERVE;
            end
         end
         SERVE: begin
            if (empty[ptr_q] || def_q[ptr_q] == '0) begin
               def_d[ptr_q] = '0;
               state_d      = IDLE;
            end else if (xfer) begin
               def_d[ptr_q] = def_q[ptr_q] - 1'b1;
               if (cnt_d[ptr_q] == '0 || def_q[ptr_q] == 1) begin
                  def_d[ptr_q] = '0;
                  state_d      = IDLE;
               end
            end
         end
      endcase
   end

   // Arbiter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= CW'(NUM_REQS - 1);
         for (int i = 0; i < NUM_REQS; i++) def_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         def_q   <= def_d;
      end
   end

   // FIFO pointers and occupancy; wrap falls out of the power-of-two depth
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (wr_en[i]) wp_q[i] <= wp_q[i] + AW'(1);
            if (pop[i])   rp_q[i] <= rp_q[i] + AW'(1);
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // FIFO storage; contents are don't-care once the pointers reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQS; i++) begin
         if (wr_en[i]) mem_q[i][wp_q[i]] <= din[i];
      end
   end

`ifdef DWRR_DROP_CNT_EN
   logic [7:0] drop_q [NUM_REQS];

   // Count pushes refused because the FIFO stayed full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQS; i++) drop_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (push[i] && !wr_en[i] && drop_q[i] != 8'hFF)
               drop_q[i] <= drop_q[i] + 8'd1;
         end
      end
   end

   // Flatten the counters onto the output bus
   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) drop_cnt[i*8 +: 8] = drop_q[i];
   end
`endif

endmodule

// File: tb/tb_dwrr_fifo_mux.sv
// tb_dwrr_fifo_mux: directed vectors, corner sequences and random traffic
// checked against a queue-based model of the DWRR FIFO mux.
module tb_dwrr_fifo_mux;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [3:0]  push;
   logic [31:0] flat_data_in;
   logic [15:0] quantums;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  data_out;
   logic [3:0]  gnt;
   logic [1:0]  out_chan;
   logic [3:0]  full;
   logic [3:0]  empty;
`ifdef DWRR_DROP_CNT_EN
   logic [31:0] drop_cnt;
`endif

   dwrr_fifo_mux #(
      .NUM_REQS(4), .WIDTH(8), .DEPTH(DEPTH), .QWID(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .push(push),
      .flat_data_in(flat_data_in),
      .quantums(quantums),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .data_out(data_out),
      .gnt(gnt),
      .out_chan(out_chan),
      .full(full),
      .empty(empty)
`ifdef DWRR_DROP_CNT_EN
      ,
      .drop_cnt(drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: one queue per channel plus the serving channel
   logic [7:0] mq [4][$];
   int         cred [4];
   int         mdrop [4];
   int         cur;
   bit         serving;

   typedef struct {
      logic [3:0]  push;
      logic [31:0] data;
      logic        ready;
      logic        ev;
      logic [7:0]  ed;
      logic [3:0]  eg;
      logic [1:0]  ec;
      logic [3:0]  ee;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mq[i].delete();
         cred[i]  = 0;
         mdrop[i] = 0;
      end
      cur     = 3;
      serving = 1'b0;
   endtask

   task automatic model_check();
      logic       mv;
      logic [7:0] md;
      logic [3:0] mg, mf, me;
      mv = serving && mq[cur].size() > 0 && cred[cur] != 0;
      md = mv ? mq[cur][0] : 8'h00;
      mg = (mv && out_ready) ? 4'(1 << cur) : 4'h0;
      for (int i = 0; i < 4; i++) begin
         mf[i] = (mq[i].size() == DEPTH);
         me[i] = (mq[i].size() == 0);
      end
      chk("model",
          64'({out_valid, data_out, gnt, out_chan, full, empty}),
          64'({mv, md, mg, 2'(cur), mf, me}));
`ifdef DWRR_DROP_CNT_EN
      for (int i = 0; i < 4; i++)
         chk("model_drop", 64'(drop_cnt[i*8 +: 8]), 64'(mdrop[i]));
`endif
   endtask

   task automatic model_step();
      int psz [4];
      bit pop;
      bit found;
      int base;
      int j;
      int q;
      pop = serving && mq[cur].size() > 0 && cred[cur] != 0 && out_ready;
      for (int i = 0; i < 4; i++) psz[i] = mq[i].size();
      for (int i = 0; i < 4; i++) begin
         if (pop && i == cur) void'(mq[i].pop_front());
         if (push[i]) begin
            if (psz[i] < DEPTH || (pop && i == cur))
               mq[i].push_back(flat_data_in[i*8 +: 8]);
            else if (mdrop[i] < 255)
               mdrop[i]++;
         end
      end
      if (!serving) begin
         found = 1'b0;
         base  = cur;
         for (int k = 1; k <= 4; k++) begin
            j = (base + k) % 4;
            q = int'(quantums[j*4 +: 4]);
            if (!found && psz[j] > 0 && q != 0) begin
               found   = 1'b1;
               cur     = j;
               cred[j] = (cred[j] + q > 31) ? 31 : cred[j] + q;
               serving = 1'b1;
            end
         end
      end else if (psz[cur] == 0 || cred[cur] == 0) begin
         cred[cur] = 0;
         serving   = 1'b0;
      end else if (pop) begin
         cred[cur]--;
         if (mq[cur].size() == 0 || cred[cur] == 0) begin
            cred[cur] = 0;
            serving   = 1'b0;
         end
      end
   endtask

   task automatic drive(input logic [3:0] p, input logic [31:0] d,
                        input logic [15:0] q, input logic r);
      @(negedge clk);
      push         = p;
      flat_data_in = d;
      quantums     = q;
      out_ready    = r;
      #1;
      model_check();
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b0;
      push         = '0;
      flat_data_in = '0;
      out_ready    = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_g [13];
      int got;

      tbl[0] = '{4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 8'h00, 4'h0, 2'd3, 4'b1111};
      tbl[1] = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 2'd3, 4'b1011};
      tbl[2] = '{4'b0000, 32'h0,         1'b0, 1'b1, 8'hA5, 4'h0, 2'd2, 4'b1011};
      tbl[3] = '{4'b0000, 32'h0,         1'b0, 1'b1, 8'hA5, 4'h0, 2'd2, 4'b1011};
      tbl[4] = '{4'b0000, 32'h0,         1'b0, 1'b1, 8'hA5, 4'h0, 2'd2, 4'b1011};
      tbl[5] = '{4'b0000, 32'h0,         1'b1, 1'b1, 8'hA5, 4'b0100, 2'd2, 4'b1011};
      tbl[6] = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 2'd2, 4'b1111};
      tbl[7] = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 2'd2, 4'b1111};
      exp_g = '{0, 0, -1, 1, -1, 0, 0, -1, 1, -1, 1, -1, 1};

      rst          = 1'b0;
      push         = '0;
      flat_data_in = '0;
      quantums     = '0;
      out_ready    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset_outs",
          64'({out_valid, data_out, gnt, out_chan, full, empty}),
          64'({1'b0, 8'h00, 4'h0, 2'd3, 4'h0, 4'hF}));
`ifdef DWRR_DROP_CNT_EN
      chk("reset_drop", 64'(drop_cnt), 64'(0));
`endif
      rst = 1'b1;

      // Single push latency, stall hold and release
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].push, tbl[i].data, 16'h1111, tbl[i].ready);
         chk($sformatf("vec%0d", i),
             64'({out_valid, data_out, gnt, out_chan, empty}),
             64'({tbl[i].ev, tbl[i].ed, tbl[i].eg, tbl[i].ec, tbl[i].ee}));
      end

      // Weighted order with quantums 2,1,1,1
      do_reset();
      for (int i = 0; i < 4; i++)
         drive(4'b0011, 32'h0000_1000 | 32'(i) | (32'(i) << 8),
               16'h1112, 1'b0);
      for (int c = 0; c < 13; c++) begin
         drive(4'b0000, 32'h0, 16'h1112, 1'b1);
         got = -1;
         for (int i = 0; i < 4; i++) if (gnt[i]) got = i;
         chk($sformatf("order%0d", c), 64'(got), 64'(exp_g[c]));
      end

      // Overfill channel 1, then push and pop together while full
      do_reset();
      for (int i = 0; i < 7; i++)
         drive(4'b0010, 32'(8'h10 + i) << 8, 16'h1111, 1'b0);
      drive(4'b0000, 32'h0, 16'h1111, 1'b0);
      chk("full1", 64'(full[1]), 64'(1));
`ifdef DWRR_DROP_CNT_EN
      chk("drop1", 64'(drop_cnt[15:8]), 64'(3));
`endif
      drive(4'b0010, 32'h0000_2000, 16'h1111, 1'b1);
      chk("pushpop_gnt", 64'(gnt), 64'(4'b0010));
      drive(4'b0000, 32'h0, 16'h1111, 1'b0);
      chk("full1_hold", 64'(full[1]), 64'(1));
      for (int i = 0; i < 12; i++) drive(4'b0000, 32'h0, 16'h1111, 1'b1);
      chk("drained", 64'(empty), 64'(4'hF));

      // Zero quantum channel is never served
      do_reset();
      drive(4'b1000, 32'h7700_0000, 16'h0111, 1'b1);
      for (int i = 0; i < 8; i++) begin
         drive(4'b0000, 32'h0, 16'h0111, 1'b1);
         chk("zero_q", 64'({out_valid, gnt}), 64'(0));
      end
      chk("zero_q_kept", 64'(empty[3]), 64'(0));

      // Asynchronous reset during a stalled SERVE
      do_reset();
      drive(4'b0001, 32'h0000_00C1, 16'h1111, 1'b0);
      drive(4'b0001, 32'h0000_00C2, 16'h1111, 1'b0);
      drive(4'b0000, 32'h0, 16'h1111, 1'b0);
      chk("pre_rst_valid", 64'({out_valid, data_out}), 64'({1'b1, 8'hC1}));
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst",
          64'({out_valid, data_out, gnt, out_chan, full, empty}),
          64'({1'b0, 8'h00, 4'h0, 2'd3, 4'h0, 4'hF}));
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(4'b0000, 32'h0, 16'h1111, 1'b1);
         chk("post_rst", 64'({out_valid, empty}), 64'({1'b0, 4'hF}));
      end

      // Random traffic against the model
      do_reset();
      quantums = 16'h1111;
      for (int c = 0; c < 1500; c++) begin
         logic [15:0] q;
         q = (c % 50 == 0) ? 16'($urandom) : quantums;
         drive(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
               $urandom, q, ($urandom_range(0, 3) != 0));
      end
      for (int c = 0; c < 60; c++) drive(4'b0000, 32'h0, 16'h1111, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
